interrupt_controller16: RTL

INTERRUPT_CONTROLLER16 -- requirements
Module: interrupt_controller16

---
 rtl/interrupt_controller16.sv | 113 +++++++++++
 1 files changed

// File: rtl/interrupt_controller16.sv
// 16-source interrupt controller: level/edge sampling, enable mask, fixed
// priority selection (bit 0 highest) and a non-nesting request/service handshake.
//
// state   | meaning
// --------|-------------------------------------------------------------
// IDLE    | nothing presented; choose lowest eligible source if any
// REQUEST | irqRequest high, irqIndex frozen until acknowledge/withdrawal
// SERVICE | CPU servicing serviceIndex; wait for endOfInterrupt
module interrupt_controller16 #(
  parameter logic [15:0] EDGE_SOURCES = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irqInputs,
  input  logic        maskWriteEnable,
  input  logic [15:0] maskWriteData,
  output logic [15:0] mask,
  output logic [15:0] pendingSignals,
  output logic        irqRequest,
  output logic [3:0]  irqIndex,
  input  logic        acknowledge,
  input  logic        endOfInterrupt,
  output logic        inService,
  output logic [3:0]  serviceIndex
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_sampled;
  logic [15:0] r_pend_edge;
  logic [15:0] r_mask;
  logic [3:0]  r_irq_index;
  logic [3:0]  r_service_index;

  logic [15:0] w_pending;
  logic [15:0] w_eligible;
  logic [15:0] w_edge_set;
  logic [15:0] w_edge_clr;
  logic        w_accept;
  logic        w_any;
  logic [3:0]  w_sel_idx;

  assign w_accept   = (r_state == S_REQUEST) && acknowledge;
  assign w_edge_set = irqInputs & ~r_sampled;
  assign w_edge_clr = w_accept ? (16'h0001 << r_irq_index) : 16'h0000;

  // Level sources follow the sampled input; edge sources hold a latched bit.
  assign w_pending  = (EDGE_SOURCES & r_pend_edge) | (~EDGE_SOURCES & r_sampled);
  assign w_eligible = w_pending & r_mask;
  assign w_any      = |w_eligible;

  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_eligible[i]) w_sel_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sampled   <= 16'h0000;
      r_pend_edge <= 16'h0000;
      r_mask      <= 16'h0000;
    end else begin
      r_sampled   <= irqInputs;
      // Set after clear so a new edge during acknowledge is not lost.
      r_pend_edge <= ((r_pend_edge & ~w_edge_clr) | w_edge_set) & EDGE_SOURCES;
      if (maskWriteEnable) r_mask <= maskWriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_irq_index     <= 4'd0;
      r_service_index <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_REQUEST;
            r_irq_index <= w_sel_idx;
          end
        end
        S_REQUEST: begin
          if (acknowledge) begin
            r_state         <= S_SERVICE;
            r_service_index <= r_irq_index;
          end else if (!w_eligible[r_irq_index]) begin
            r_state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (endOfInterrupt) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mask           = r_mask;
  assign pendingSignals = w_pending;
  assign irqRequest     = (r_state == S_REQUEST);
  assign inService      = (r_state == S_SERVICE);
  assign irqIndex       = r_irq_index;
  assign serviceIndex   = r_service_index;

endmodule
